// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One ARB cycle per grant, then a burst of up to MAX_BURST beats from the winner.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_mask,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    grant_d;
    logic [ID_W-1:0]    last_id, last_d;
    logic [CNT_W-1:0]   beat_cnt, cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    scan_idx;
    logic               cur_valid;
    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    assign eligible  = req_valid & req_mask;
    assign cur_valid = req_valid[grant_id];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Scan from the farthest offset down so the nearest eligible index after last_id wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            scan_idx = ID_W'((int'(last_id) + off) % NUM_REQ);
            if (eligible[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d     = state;
        grant_d     = grant_id;
        last_d      = last_id;
        cnt_d       = beat_cnt;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        fifo_din    = '0;
        grant_valid = 1'b0;

        case (state)
            ARB: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                grant_valid         = 1'b1;
                req_ready[grant_id] = !fifo_full;
                fifo_wr_en          = cur_valid && !fifo_full;
                fifo_din            = data_arr[grant_id];
                // A producer dropping valid ends the burst even while the FIFO is stalled.
                if (!cur_valid) begin
                    state_d = ARB;
                    last_d  = grant_id;
                end else if (fifo_wr_en) begin
                    cnt_d = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_d = ARB;
                        last_d  = grant_id;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            grant_id <= '0;
            last_id  <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            grant_id <= grant_d;
            last_id  <= last_d;
            beat_cnt <= cnt_d;
        end
    end

    a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr_en && fifo_full));

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with a behavioural DEPTH=16 FIFO downstream.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic        tb_full;
    logic        e2e;
    logic [3:0]  seq [4];
    logic [7:0]  fmem [16];
    logic [3:0]  wptr;
    logic [4:0]  fcount;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_full = e2e ? (fcount == 5'd16) : tb_full;

    // Producer i presents {A+i, seq}; seq advances on each accepted beat.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = {4'(10 + i), seq[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) seq[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            fcount <= '0;
            ovf    <= 1'b0;
        end else if (fifo_wr_en) begin
            if (fcount == 5'd16) begin
                ovf <= 1'b1;
            end else begin
                fmem[wptr] <= fifo_din;
                wptr       <= wptr + 4'd1;
                fcount     <= fcount + 5'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_mask  = 4'hF;
        tb_full   = 1'b0;
        e2e       = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'b0001;
        step();
        n_checks++;
        if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !== {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0}) begin
            n_fail++;
            $display("FAIL reset_pre_burst: got %b expected %b",
                     {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din}, {1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0});
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_zero: got %h expected 0000",
                     {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din});
        end
        n_checks++;
        if ({dut.last_id, dut.beat_cnt} !== {2'd3, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_regs: got last_id=%0d beat_cnt=%0d expected 3/0", dut.last_id, dut.beat_cnt);
        end
        req_valid = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({grant_valid, req_ready, fifo_wr_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_arb_cycle: got %b expected 000000", {grant_valid, req_ready, fifo_wr_en});
        end
        step();
        n_checks++;
        if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !== {1'b1, 2'd2, 4'b0100, 1'b1, 8'hC0}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected %b",
                     {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din}, {1'b1, 2'd2, 4'b0100, 1'b1, 8'hC0});
        end
    endtask

    task automatic test_rotation();
        int g;
        do_reset();
        req_valid = 4'hF;
        #1;
        for (int r = 0; r < 5; r++) begin
            g = r % 4;
            for (int b = 0; b < 4; b++) begin
                step();
                n_checks++;
                if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !==
                    {1'b1, 2'(g), 4'(1 << g), 1'b1, 4'(10 + g), 4'((r / 4) * 4 + b)}) begin
                    n_fail++;
                    $display("FAIL rotation_beat r=%0d b=%0d: got %b expected %b", r, b,
                             {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din},
                             {1'b1, 2'(g), 4'(1 << g), 1'b1, 4'(10 + g), 4'((r / 4) * 4 + b)});
                end
            end
            step();
            n_checks++;
            if ({grant_valid, req_ready, fifo_wr_en, fifo_din} !== 14'b0) begin
                n_fail++;
                $display("FAIL rotation_arb r=%0d: got %b expected 0", r,
                         {grant_valid, req_ready, fifo_wr_en, fifo_din});
            end
        end
    endtask

    task automatic test_early_end();
        do_reset();
        req_valid = 4'b1010;
        for (int b = 0; b < 2; b++) begin
            step();
            n_checks++;
            if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !== {1'b1, 2'd1, 4'b0010, 1'b1, 4'hB, 4'(b)}) begin
                n_fail++;
                $display("FAIL early_beat b=%0d: got %b expected %b", b,
                         {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din}, {1'b1, 2'd1, 4'b0010, 1'b1, 4'hB, 4'(b)});
            end
        end
        step();
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if ({grant_valid, grant_id, req_ready, fifo_wr_en} !== {1'b1, 2'd1, 4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL early_drop_cycle: got %b expected %b",
                     {grant_valid, grant_id, req_ready, fifo_wr_en}, {1'b1, 2'd1, 4'b0010, 1'b0});
        end
        step();
        n_checks++;
        if ({grant_valid, dut.last_id, seq[1]} !== {1'b0, 2'd1, 4'd2}) begin
            n_fail++;
            $display("FAIL early_end_arb: got gv=%b last_id=%0d beats=%0d expected 0/1/2",
                     grant_valid, dut.last_id, seq[1]);
        end
        step();
        n_checks++;
        if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !== {1'b1, 2'd3, 4'b1000, 1'b1, 8'hD0}) begin
            n_fail++;
            $display("FAIL early_next_grant: got %b expected %b",
                     {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din}, {1'b1, 2'd3, 4'b1000, 1'b1, 8'hD0});
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0001;
        step();
        step();
        n_checks++;
        if ({fifo_wr_en, fifo_din} !== {1'b1, 8'hA1}) begin
            n_fail++;
            $display("FAIL stall_pre: got %b expected %b", {fifo_wr_en, fifo_din}, {1'b1, 8'hA1});
        end
        step();
        tb_full = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({grant_valid, grant_id, req_ready, fifo_wr_en, dut.beat_cnt} !== {1'b1, 2'd0, 4'b0000, 1'b0, 3'd2}) begin
                n_fail++;
                $display("FAIL stall_hold k=%0d: got %b expected %b", k,
                         {grant_valid, grant_id, req_ready, fifo_wr_en, dut.beat_cnt}, {1'b1, 2'd0, 4'b0000, 1'b0, 3'd2});
            end
            if (k < 2) step();
        end
        step();
        tb_full = 1'b0;
        #1;
        for (int b = 2; b < 4; b++) begin
            n_checks++;
            if ({grant_valid, req_ready, fifo_wr_en, fifo_din} !== {1'b1, 4'b0001, 1'b1, 4'hA, 4'(b)}) begin
                n_fail++;
                $display("FAIL stall_resume b=%0d: got %b expected %b", b,
                         {grant_valid, req_ready, fifo_wr_en, fifo_din}, {1'b1, 4'b0001, 1'b1, 4'hA, 4'(b)});
            end
            step();
        end
        n_checks++;
        if ({grant_valid, seq[0]} !== {1'b0, 4'd4}) begin
            n_fail++;
            $display("FAIL stall_total: got gv=%b beats=%0d expected 0/4", grant_valid, seq[0]);
        end
    endtask

    task automatic test_mask();
        int grants [4] = '{1, 3, 1, 3};
        int bases  [4] = '{0, 0, 4, 4};
        int g;
        do_reset();
        req_mask  = 4'b1010;
        req_valid = 4'hF;
        #1;
        for (int r = 0; r < 4; r++) begin
            g = grants[r];
            for (int b = 0; b < 4; b++) begin
                step();
                if (r == 2 && b == 1) begin
                    req_mask = 4'b1000;
                    #1;
                end
                n_checks++;
                if ({grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din} !==
                    {1'b1, 2'(g), 4'(1 << g), 1'b1, 4'(10 + g), 4'(bases[r] + b)}) begin
                    n_fail++;
                    $display("FAIL mask_beat r=%0d b=%0d: got %b expected %b", r, b,
                             {grant_valid, grant_id, req_ready, fifo_wr_en, fifo_din},
                             {1'b1, 2'(g), 4'(1 << g), 1'b1, 4'(10 + g), 4'(bases[r] + b)});
                end
            end
            step();
            n_checks++;
            if ({grant_valid, req_ready, fifo_wr_en} !== 6'b0) begin
                n_fail++;
                $display("FAIL mask_arb r=%0d: got %b expected 0", r, {grant_valid, req_ready, fifo_wr_en});
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        e2e       = 1'b1;
        req_valid = 4'hF;
        #1;
        c = 0;
        while (fcount != 5'd16 && c < 40) begin
            step();
            c++;
        end
        n_checks++;
        if (fcount !== 5'd16 || c != 20) begin
            n_fail++;
            $display("FAIL e2e_fill: got count=%0d after %0d cycles expected 16 after 20", fcount, c);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if ({fifo_full, fifo_wr_en, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL e2e_hold_full k=%0d: got %b expected 100000", k, {fifo_full, fifo_wr_en, req_ready});
            end
            step();
        end
        n_checks++;
        if ({ovf, fcount} !== {1'b0, 5'd16}) begin
            n_fail++;
            $display("FAIL e2e_no_overflow: got ovf=%b count=%0d expected 0/16", ovf, fcount);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (fmem[k] !== {4'(10 + k / 4), 4'(k % 4)}) begin
                n_fail++;
                $display("FAIL e2e_readback k=%0d: got %h expected %h", k, fmem[k], {4'(10 + k / 4), 4'(k % 4)});
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_mask  = 4'hF;
        tb_full   = 1'b0;
        e2e       = 1'b0;
        test_reset();
        test_rotation();
        test_early_end();
        test_full_stall();
        test_mask();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` write port (`wr_en`/`din`/`full`) among `NUM_REQ` producers. Grants one producer at a time, lets it stream a burst of up to `MAX_BURST` beats, then rotates priority. Sits directly upstream of the FIFO. Its outputs drive the FIFO write port, and the FIFO's `full` feeds back combinationally.

## Interface
- `NUM_REQ`, default 4: number of producers, ≥2.
- `WIDTH`, default 8: data width, matches the FIFO `WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-producer data valid.
- `req_data`  in  NUM_REQ*WIDTH  producer i data at bits [i*WIDTH +: WIDTH].
- `req_mask`  in  NUM_REQ  1 = producer eligible for arbitration.
- `req_ready`  out  NUM_REQ  one-hot or zero; beat accepted when `req_valid[i] && req_ready[i]`.
- `fifo_full`  in  1  from FIFO `full`.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_din`  out  WIDTH  to FIFO `din`.
- `grant_valid`  out  1  a burst is in progress.
- `grant_id`  out  ID_W  index of the granted producer.

## Operation
- FSM has two states: ARB and BURST. Registered state is `state`, `grant_id`, `last_id` and `beat_cnt` (width `$clog2(MAX_BURST+1)`).
- ARB:
  - `grant_valid=0` and all `req_ready=0`.
  - Eligible set is `req_valid & req_mask`.
  - If the set is non-empty, pick the first eligible index scanning `last_id+1, last_id+2, …` modulo `NUM_REQ`.
  - Register it into `grant_id`, clear `beat_cnt`, then go to BURST.
  - If the set is empty, stay in ARB.
- BURST:
  - `grant_valid=1`.
  - `req_ready[grant_id] = !fifo_full`.
  - `fifo_wr_en = req_valid[grant_id] && !fifo_full`.
  - `fifo_din = req_data[grant_id]`, which is don't-care when `fifo_wr_en=0`.
- A beat is transferred when `fifo_wr_en=1`. On each beat, `beat_cnt` increments.
- Leave BURST for ARB, setting `last_id <= grant_id`, when either:
  - a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[grant_id]==0` in a BURST cycle. Nothing transfers that cycle.
- `fifo_full=1` in BURST: hold the grant. No beat occurs, `beat_cnt` is unchanged, and the stall does not end the burst.
- `req_mask` is sampled only in ARB. Deasserting the mask mid-burst does not cut the burst short.
- A producer must hold `req_valid`/`req_data` stable until ready. Dropping `valid` ends its burst.
- The arbiter never asserts `fifo_wr_en` while `fifo_full=1`, so no write is dropped by the FIFO.
- Reset values:
  - `state=ARB`, `grant_id=0`, `last_id=NUM_REQ-1` (producer 0 wins first), `beat_cnt=0`.
  - All outputs are 0: `fifo_wr_en=0`, `req_ready=0`, `grant_valid=0`, `grant_id=0`, `fifo_din=0`.
- Reset asserted mid-burst aborts the burst immediately. Any beat that was combinationally presented in that cycle is not written. After deassertion, arbitration restarts from producer 0.

## Timing
- `req_ready`, `fifo_wr_en` and `fifo_din` are combinational from registered state, `req_valid`, `req_data` and `fifo_full`. There is no register between a producer and the FIFO.
- Arbitration costs one ARB cycle per grant. The first beat can transfer in the cycle after `req_valid` is seen in ARB.
- With no stalls and `MAX_BURST=4`, throughput is at best 4 beats per 5 cycles.
- Worst-case wait for an eligible, continuously-valid producer: `(NUM_REQ-1)*(MAX_BURST+1)` cycles plus stalls caused by `fifo_full`.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → all outputs 0 immediately. Release with only producer 2 valid → ARB 1 cycle, then `grant_id=2`, `req_ready=4'b0100`.
- **Round-robin rotation:** all 4 valid, `MAX_BURST=4`, FIFO never full → grants in order 0,1,2,3,0. Each grant gives exactly 4 beats followed by 1 ARB cycle. `fifo_din` carries producer i's data during grant i.
- **Early burst end:** producer 1 drops `valid` after 2 beats while producer 3 is valid → burst ends with 2 beats, next grant is 3, and `last_id` becomes 1.
- **Full stall:** `fifo_full=1` for 3 cycles mid-burst → `fifo_wr_en=0` and `req_ready=0` during the stall, grant held, `beat_cnt` frozen. After `full` drops, the remaining beats complete for a total of 4.
- **Mask:** `req_mask=4'b1010` with all valid → only 1 and 3 are granted, alternating. Clearing mask bit 1 mid-burst → the current burst of 1 finishes all 4 beats.
- **End-to-end with the FIFO:** drive 16 beats into a DEPTH=16 FIFO → `fifo_full` asserts and no further `fifo_wr_en` follows. Read back → data order matches the grant order exactly, with no loss or duplication.
